bcd_entry_reg: RTL and testbench

BCD_ENTRY_REG -- requirements
Module: bcd_entry_reg

---
 rtl/bcd_entry_reg.sv | 112 +++++++++++
 tb/tb_bcd_entry_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry_reg.sv
// Keypad BCD operand entry register: collects decimal digits, supports backspace,
// clear and enter, then offers the packed BCD operand downstream with valid/ready.
module bcd_entry_reg #(
  parameter int unsigned DIGIT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [4:0]             key_code,
  output logic                   key_ready,
  output logic [4*DIGIT_NUM-1:0] operand,
  output logic                   operand_valid,
  input  logic                   operand_ready,
  output logic [3:0]             digit_count,
  output logic                   overflow
);

  localparam int unsigned OpW      = 4 * DIGIT_NUM;
  localparam logic [3:0]  DigitMax = 4'(DIGIT_NUM);

  localparam logic [4:0] KeyBksp  = 5'd10;
  localparam logic [4:0] KeyClear = 5'd11;
  localparam logic [4:0] KeyEnter = 5'd12;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StEntry   = 2'd1,
    StPresent = 2'd2
  } state_e;

  state_e           state_q;
  logic [OpW-1:0]   operand_q;
  logic [3:0]       count_q;
  logic             ovf_q;
  logic             key_ready_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      operand_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      key_ready_q <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty, StEntry: begin
          if (key_valid) begin
            if (key_code <= 5'd9) begin
              if (count_q == 4'd0) begin
                // Leading zeros are swallowed so digit_count tracks significant digits.
                if (key_code[3:0] != 4'd0) begin
                  operand_q <= OpW'(key_code[3:0]);
                  count_q   <= 4'd1;
                  state_q   <= StEntry;
                end
              end else if (count_q < DigitMax) begin
                operand_q <= {operand_q[OpW-5:0], key_code[3:0]};
                count_q   <= count_q + 4'd1;
              end else begin
                ovf_q <= 1'b1;
              end
            end else if (key_code == KeyBksp) begin
              if (count_q != 4'd0) begin
                operand_q <= {4'h0, operand_q[OpW-1:4]};
                count_q   <= count_q - 4'd1;
                if (count_q == 4'd1) begin
                  state_q <= StEmpty;
                end
              end
            end else if (key_code == KeyClear) begin
              operand_q <= '0;
              count_q   <= '0;
              ovf_q     <= 1'b0;
              state_q   <= StEmpty;
            end else if (key_code == KeyEnter) begin
              state_q     <= StPresent;
              key_ready_q <= 1'b0;
              valid_q     <= 1'b1;
            end
          end
        end
        StPresent: begin
          if (operand_ready) begin
            operand_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= StEmpty;
            key_ready_q <= 1'b1;
            valid_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= StEmpty;
          operand_q   <= '0;
          count_q     <= '0;
          ovf_q       <= 1'b0;
          key_ready_q <= 1'b1;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready     = key_ready_q;
  assign operand_valid = valid_q;
  assign operand       = operand_q;
  assign digit_count   = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_bcd_entry_reg.sv
// Randomized bench for bcd_entry_reg; the reference keeps the operand as a plain
// decimal integer and converts it to packed BCD for comparison.
module tb_bcd_entry_reg;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [31:0] operand;
  logic        operand_valid;
  logic        operand_ready;
  logic [3:0]  digit_count;
  logic        overflow;

  int checks;
  int errors;

  // Reference model state
  int unsigned val_m;
  bit          ovf_m;
  bit          present_m;

  bcd_entry_reg #(
    .DIGIT_NUM(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .operand      (operand),
    .operand_valid(operand_valid),
    .operand_ready(operand_ready),
    .digit_count  (digit_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int unsigned v);
    int n;
    int unsigned x;
    n = 0;
    x = v;
    while (x != 0) begin
      n++;
      x = x / 10;
    end
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".operand"}, operand, to_bcd(val_m));
    check({tag, ".count"}, 32'(digit_count), 32'(ndig(val_m)));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ".key_ready"}, 32'(key_ready), 32'(!present_m));
    check({tag, ".valid"}, 32'(operand_valid), 32'(present_m));
  endtask

  task automatic model_step(input logic kv, input logic [4:0] kc, input logic ordy);
    if (present_m) begin
      if (ordy) begin
        val_m     = 0;
        ovf_m     = 1'b0;
        present_m = 1'b0;
      end
    end else if (kv) begin
      if (kc <= 5'd9) begin
        if (!(val_m == 0 && kc == 5'd0)) begin
          if (ndig(val_m) < 8) val_m = val_m * 10 + int'(kc);
          else ovf_m = 1'b1;
        end
      end else if (kc == 5'd10) begin
        val_m = val_m / 10;
      end else if (kc == 5'd11) begin
        val_m = 0;
        ovf_m = 1'b0;
      end else if (kc == 5'd12) begin
        present_m = 1'b1;
      end
    end
  endtask

  // Called at a negedge: drive, take one rising edge, advance model, check at next negedge.
  task automatic cycle(input string tag, input logic kv, input logic [4:0] kc,
                       input logic ordy);
    key_valid     = kv;
    key_code      = kc;
    operand_ready = ordy;
    @(posedge clk);
    model_step(kv, kc, ordy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic key(input string tag, input logic [4:0] kc);
    cycle(tag, 1'b1, kc, 1'b0);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic mid_reset(input string tag);
    key_valid     = 1'b0;
    operand_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    val_m     = 0;
    ovf_m     = 1'b0;
    present_m = 1'b0;
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    val_m         = 0;
    ovf_m         = 1'b0;
    present_m     = 1'b0;
    reset         = 1'b1;
    key_valid     = 1'b0;
    key_code      = 5'd0;
    operand_ready = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1,2,3, enter, hold with ready low
    key("r31", 5'd1); key("r31", 5'd2); key("r31", 5'd3); key("r31", 5'd12);
    cycle("r31_hold", 1'b1, 5'd4, 1'b0);
    cycle("r31_hold", 1'b0, 5'd0, 1'b0);
    check("r31_op", operand, 32'h0000_0123);
    check("r31_valid", 32'(operand_valid), 32'd1);
    check("r31_kready", 32'(key_ready), 32'd0);
    cycle("r31_xfer", 1'b0, 5'd0, 1'b1);

    // 0,0,7, enter, one-cycle transfer
    key("r32", 5'd0); key("r32", 5'd0);
    check("r32_lz", 32'(digit_count), 32'd0);
    key("r32", 5'd7); key("r32", 5'd12);
    check("r32_op", operand, 32'h0000_0007);
    cycle("r32_xfer", 1'b1, 5'd5, 1'b1);
    check("r32_after", 32'(operand_valid), 32'd0);

    // nine digits, then backspace
    for (int d = 1; d <= 9; d++) key("r33", 5'(d));
    check("r33_op", operand, 32'h1234_5678);
    check("r33_ovf", 32'(overflow), 32'd1);
    key("r33_bs", 5'd10);
    check("r33_bs_op", operand, 32'h0123_4567);
    check("r33_bs_ovf", 32'(overflow), 32'd1);
    key("r33_clr", 5'd11);

    // 5, bs, bs, enter
    key("r34", 5'd5); key("r34", 5'd10); key("r34", 5'd10); key("r34", 5'd12);
    check("r34_valid", 32'(operand_valid), 32'd1);
    check("r34_op", operand, 32'h0);
    cycle("r34_xfer", 1'b0, 5'd0, 1'b1);

    // 9,9, clear, ignored code
    key("r35", 5'd9); key("r35", 5'd9); key("r35", 5'd11); key("r35_ign", 5'd20);
    check("r35_kready", 32'(key_ready), 32'd1);

    // reset in PRESENT, then immediate key acceptance
    key("r36", 5'd4); key("r36", 5'd12);
    mid_reset("r36_rst");
    key("r30_first", 5'd6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      logic [4:0]  kc;
      sel = $urandom_range(0, 99);
      if (sel < 60) kc = 5'($urandom_range(0, 9));
      else if (sel < 70) kc = 5'd10;
      else if (sel < 73) kc = 5'd11;
      else if (sel < 80) kc = 5'd12;
      else kc = 5'($urandom_range(13, 31));
      cycle("rand", ($urandom_range(0, 9) != 0), kc, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
